// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for alu_seq and muldiv_iter.
//   base_op_e   : funct3 encodings for the base integer ops (m = 0)
//   m_op_e      : funct3 encodings for the M-extension ops (m = 1)
//   state_e     : sequencer states
//   div_special : returns {signed_overflow, zero_divisor} for a divide/remainder.
//                 It works on XLEN values of up to XLEN_MAX bits.
package alu_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        F_ADD  = 3'd0,
        F_SLL  = 3'd1,
        F_SLT  = 3'd2,
        F_SLTU = 3'd3,
        F_XOR  = 3'd4,
        F_SR   = 3'd5,
        F_OR   = 3'd6,
        F_AND  = 3'd7
    } base_op_e;

    typedef enum logic [2:0] {
        F_MUL    = 3'd0,
        F_MULH   = 3'd1,
        F_MULHSU = 3'd2,
        F_MULHU  = 3'd3,
        F_DIV    = 3'd4,
        F_DIVU   = 3'd5,
        F_REM    = 3'd6,
        F_REMU   = 3'd7
    } m_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Operands arrive zero-extended to XLEN_MAX; only the low xlen bits matter.
    function automatic logic [1:0] div_special(input logic [XLEN_MAX-1:0] a,
                                               input logic [XLEN_MAX-1:0] b,
                                               input int xlen,
                                               input logic sgn);
        logic [XLEN_MAX-1:0] mask;
        logic [XLEN_MAX-1:0] min_neg;
        logic zero;
        logic ovf;
        mask    = (xlen >= XLEN_MAX) ? '1 : ((XLEN_MAX'(1) << xlen) - XLEN_MAX'(1));
        min_neg = XLEN_MAX'(1) << (xlen - 1);
        zero    = ((b & mask) == '0);
        ovf     = sgn && ((a & mask) == min_neg) && ((b & mask) == mask);
        return {ovf, zero};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiplier / restoring divider for alu_seq.
// Only compiled when ALU_MULDIV_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin XLEN iterations
//   op         : M-extension funct3 (m_op_e)
//   a, b       : operands, sampled on start
//   done       : high during the last iteration; result is valid in that cycle
//   result     : sign-corrected result of the final iteration
`ifdef ALU_MULDIV_EN
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic            run;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            neg_r;
    // Multiply: {acc, lo} is the running product, lo starts as the multiplier.
    // Divide: acc is the partial remainder, lo shifts dividend out / quotient in.
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mag;

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   sum, shl;
    logic [XLEN-1:0] diff;
    logic            ge;
    logic [XLEN-1:0] acc_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_f;

    assign a_sgn = (op == F_MUL) || (op == F_MULH) || (op == F_MULHSU) ||
                   (op == F_DIV) || (op == F_REM);
    assign b_sgn = (op == F_MUL) || (op == F_MULH) || (op == F_DIV) || (op == F_REM);
    assign a_neg = a_sgn && a[XLEN-1];
    assign b_neg = b_sgn && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign done = run && (cnt == CW'(XLEN - 1));

    always_comb begin
        sum  = {1'b0, acc} + (lo[0] ? {1'b0, mag} : '0);
        shl  = {acc, lo[XLEN-1]};
        ge   = (shl >= {1'b0, mag});
        // True difference always fits in XLEN bits when ge is set.
        diff = shl[XLEN-1:0] - mag;
        if (op_q[2]) begin
            acc_n = ge ? diff : shl[XLEN-1:0];
            lo_n  = {lo[XLEN-2:0], ge};
        end else begin
            acc_n = sum[XLEN:1];
            lo_n  = {sum[0], lo[XLEN-1:1]};
        end
    end

    // Result is taken from the post-iteration values so the top can register
    // it on the same edge that completes the final iteration.
    always_comb begin
        prod   = {acc_n, lo_n};
        prod_f = neg_q ? -prod : prod;
        case (m_op_e'(op_q))
            F_MUL:                     result = prod_f[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: result = prod_f[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             result = neg_q ? -lo_n : lo_n;
            default:                   result = neg_r ? -acc_n : acc_n;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            acc   <= '0;
            lo    <= '0;
            mag   <= '0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= '0;
            op_q  <= op;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            acc   <= '0;
            lo    <= op[2] ? a_mag : b_mag;
            mag   <= op[2] ? b_mag : a_mag;
        end else if (run) begin
            acc <= acc_n;
            lo  <= lo_n;
            cnt <= cnt + CW'(1);
            if (done) run <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I/M execute unit with an XLEN-generic datapath.
// Build option: ALU_MULDIV_EN enables the M-extension ops via muldiv_iter;
// without it every m=1 op completes in one cycle with y=0, illegal=1.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : upstream handshake; a, b, sel, ext, m sampled on accept
//   out_valid, out_ready : downstream handshake; y, illegal held until taken
//   busy                 : high while an iterative op is in progress
//
// state  | meaning
// IDLE   | empty, ready for a new op
// CALC   | iterative multiply/divide running
// DONE   | result presented on y/illegal, waiting for out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      sel,
    input  logic            ext,
    input  logic            m,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y,
    output logic            illegal,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    state_e          state, state_n;
    logic            accept;
    logic            go_calc;
    logic            calc_done;
    logic [XLEN-1:0] calc_res;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] fast_res;
    logic            fast_ill;
    logic [SHW-1:0]  shamt;

    assign shamt   = b[SHW-1:0];
    // Kept in its own assignment so the shift stays arithmetic.
    assign sra_res = $signed(a) >>> shamt;

    always_comb begin
        base_res = '0;
        case (base_op_e'(sel))
            F_ADD:   base_res = ext ? a - b : a + b;
            F_SLL:   base_res = a << shamt;
            F_SLT:   base_res = XLEN'($signed(a) < $signed(b));
            F_SLTU:  base_res = XLEN'(a < b);
            F_XOR:   base_res = a ^ b;
            F_SR:    base_res = ext ? sra_res : a >> shamt;
            F_OR:    base_res = a | b;
            F_AND:   base_res = a & b;
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;

    assign {div_ovf, div_zero} = div_special(XLEN_MAX'(a), XLEN_MAX'(b), XLEN,
                                             (sel == F_DIV) || (sel == F_REM));
    // Zero divisor and signed overflow resolve without iterating; sel[1] picks REM*.
    assign special  = sel[2] && (div_zero || div_ovf);
    assign spec_res = sel[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);
    assign go_calc  = m && !special;
    assign fast_res = m ? spec_res : base_res;
    assign fast_ill = 1'b0;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && go_calc),
        .op     (sel),
        .a      (a),
        .b      (b),
        .done   (calc_done),
        .result (calc_res)
    );
`else
    assign go_calc   = 1'b0;
    assign fast_res  = m ? '0 : base_res;
    assign fast_ill  = m;
    assign calc_done = 1'b0;
    assign calc_res  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_CALC:  busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        accept = in_valid && in_ready;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept)                           state_n = go_calc ? S_CALC : S_DONE;
                else if (state == S_DONE && out_ready) state_n = S_IDLE;
            end
            S_CALC:  if (calc_done) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            illegal <= 1'b0;
        end else if (accept && !go_calc) begin
            y       <= fast_res;
            illegal <= fast_ill;
        end else if (state == S_CALC && calc_done) begin
            y       <= calc_res;
            illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a, b;
    logic [2:0]      sel;
    logic            ext, m;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;
    logic            illegal;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .ext       (ext),
        .m         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .illegal   (illegal),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operands.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [2:0] ms, input logic me, input logic mm,
                                  output logic [31:0] ey, output logic eill, output int elat);
        int sh;
        longint sa, sb, q;
        logic [63:0] p;
        sh   = int'(mb % 32);
        ey   = 32'h0;
        eill = 1'b0;
        elat = 1;
        if (!mm) begin
            case (ms)
                3'd0: ey = me ? ma - mb : ma + mb;
                3'd1: ey = ma << sh;
                3'd2: ey = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
                3'd3: ey = (ma < mb) ? 32'd1 : 32'd0;
                3'd4: ey = ma ^ mb;
                3'd5: ey = me ? ((ma >> sh) | (ma[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0))
                              : ma >> sh;
                3'd6: ey = ma | mb;
                default: ey = ma & mb;
            endcase
        end else begin
`ifdef ALU_MULDIV_EN
            if (ms < 3'd4) begin
                sa   = (ms != 3'd3) ? longint'($signed(ma)) : longint'(ma);
                sb   = (ms < 3'd2) ? longint'($signed(mb)) : longint'(mb);
                p    = 64'(sa * sb);
                ey   = (ms == 3'd0) ? p[31:0] : p[63:32];
                elat = 33;
            end else if (mb == 32'h0) begin
                ey = (ms < 3'd6) ? 32'hFFFF_FFFF : ma;
            end else if ((ms == 3'd4 || ms == 3'd6) && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                ey = (ms == 3'd4) ? ma : 32'h0;
            end else begin
                elat = 33;
                if (ms == 3'd4 || ms == 3'd6) begin
                    sa = longint'($signed(ma));
                    sb = longint'($signed(mb));
                    q  = (ms == 3'd4) ? sa / sb : sa % sb;
                    ey = 32'(q);
                end else begin
                    ey = (ms == 3'd5) ? ma / mb : ma % mb;
                end
            end
`else
            ey   = 32'h0;
            eill = 1'b1;
`endif
        end
    endfunction

    task automatic do_op(input logic [31:0] pa, input logic [31:0] pb, input logic [2:0] ps,
                         input logic pe, input logic pm, input string tag);
        logic [31:0] ey;
        logic        eill;
        int          elat, lat, nbusy, waitc;
        model(pa, pb, ps, pe, pm, ey, eill, elat);
        a = pa; b = pb; sel = ps; ext = pe; m = pm;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(posedge clk); #1; waitc++;
        end
        chk({tag, ".accept_wait"}, 32'(waitc < 100), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 1; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".y"}, y, ey);
        chk({tag, ".illegal"}, 32'(illegal), 32'(eill));
        chk({tag, ".busy_cycles"}, 32'(nbusy), (elat > 1) ? 32'(XLEN) : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] ey, pa, pb;
        logic        eill;
        int          elat, nv, r;
        logic [2:0]  ps;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sel = '0; ext = 1'b0; m = 1'b0;
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.y", y, 32'h0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(32'd5, 32'd7, 3'd0, 1'b1, 1'b0, "sub");
        do_op(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, "slt");
        do_op(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 1'b0, "sltu");
        do_op(32'h8000_0000, 32'h24, 3'd5, 1'b1, 1'b0, "sra");
        do_op(32'h8000_0000, 32'h24, 3'd5, 1'b0, 1'b0, "srl");
        do_op(32'h0000_00F1, 32'h43, 3'd1, 1'b0, 1'b0, "sll");
        do_op(32'h8000_0000, 32'h8000_0000, 3'd1, 1'b0, 1'b1, "mulh");
        do_op(32'hFFFF_FFFF, 32'd2, 3'd2, 1'b0, 1'b1, "mulhsu");
        do_op(32'hFFFF_FFFD, 32'd7, 3'd0, 1'b0, 1'b1, "mul");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, "mulhu");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1, "div_ovf");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, "rem_ovf");
        do_op(32'hDEAD_BEEF, 32'h0, 3'd5, 1'b0, 1'b1, "divu_zero");
        do_op(32'h0000_1234, 32'h0, 3'd7, 1'b0, 1'b1, "remu_zero");
        do_op(32'hFFFF_FF9C, 32'd7, 3'd4, 1'b0, 1'b1, "div");
        do_op(32'hFFFF_FF9C, 32'd7, 3'd6, 1'b0, 1'b1, "rem");
        do_op(32'hF000_0001, 32'd10, 3'd5, 1'b0, 1'b1, "divu");

        // back-to-back base ops with out_ready held high
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pa = $urandom; pb = $urandom; ps = 3'($urandom_range(0, 7));
            a = pa; b = pb; sel = ps; ext = 1'($urandom_range(0, 1)); m = 1'b0;
            model(pa, pb, ps, ext, 1'b0, ey, eill, elat);
            @(posedge clk); #1;
            chk("b2b.out_valid", 32'(out_valid), 32'd1);
            chk("b2b.y", y, ey);
        end
        in_valid = 1'b0;

        // backpressure
        pa = 32'h1357_9BDF; pb = 32'h0F0F_0F0F;
        model(pa, pb, 3'd4, 1'b0, 1'b0, ey, eill, elat);
        a = pa; b = pb; sel = 3'd4; ext = 1'b0; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        a = $urandom; b = $urandom;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.y", y, ey);
            chk("bp.illegal", 32'(illegal), 32'(eill));
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        pa = 32'h7FFF_FFFF; pb = 32'h0000_0001;
        model(pa, pb, 3'd0, 1'b0, 1'b0, ey, eill, elat);
        a = pa; b = pb; sel = 3'd0; ext = 1'b0; m = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp.in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.next_valid", 32'(out_valid), 32'd1);
        chk("bp.next_y", y, ey);

        // reset during an iterative divide
        @(posedge clk); #1;
        a = 32'd1_000_000_007; b = 32'd12345; sel = 3'd4; ext = 1'b0; m = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstcalc.out_valid", 32'(out_valid), 32'd0);
        chk("rstcalc.y", y, 32'h0);
        chk("rstcalc.busy", 32'(busy), 32'd0);
        chk("rstcalc.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("rstcalc.no_stale", 32'(nv), 32'd0);

        // randomized ops
        for (int i = 0; i < 100; i++) begin
            r  = int'($urandom_range(0, 9));
            pa = $urandom; pb = $urandom;
            if (r == 0) pb = 32'h0;
            if (r == 1) begin pa = 32'h8000_0000; pb = 32'hFFFF_FFFF; end
            if (r == 2) pb = 32'($urandom_range(1, 15));
            do_op(pa, pb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle RV32I ALU, with an XLEN-generic datapath. It executes the eight base integer ops in one cycle and the eight RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over several cycles on an iterative multiplier/divider. It sits in the execute stage between the register-read/decode stage (upstream valid/ready) and writeback (downstream valid/ready). It also fixes signed compare and arithmetic shift semantics for full-width operands.

## Interface
- XLEN, 32, operand/result width; must be a power of two, ≥8
- SHW, $clog2(XLEN), shift-amount width (localparam, not overridable)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready
- a  in  XLEN  operand rs1
- b  in  XLEN  operand rs2 / immediate
- sel  in  3  funct3
- ext  in  1  funct7[5]: SUB/SRA select (ignored when m=1)
- m  in  1  funct7[0]: M-extension op
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
- y  out  XLEN  result
- illegal  out  1  qualifies y when out_valid: op not supported in this build
- busy  out  1  high in CALC state

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; out_valid=0, y=0, illegal=0, busy=0, in_ready=1.
- in_ready = (IDLE) || (DONE && out_ready); captured operands are held in internal registers.
- Base ops (m=0), result registered and IDLE→DONE on accept:
  - sel 0: ADD/SUB
  - sel 1: SLL by b[SHW-1:0]
  - sel 2: SLT, true signed compare
  - sel 3: SLTU
  - sel 4: XOR
  - sel 5: SRL/SRA; SRA replicates a[XLEN-1]
  - sel 6: OR
  - sel 7: AND
- M ops (m=1), accept → CALC:
  - MUL*: radix-2 shift-add over XLEN iterations on magnitudes; sign is fixed up at the end.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the 2·XLEN product.
  - DIV*: restoring division over XLEN iterations.
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → a. Both take 1 cycle and skip CALC.
  - Signed overflow (a = most-negative, b = −1): DIV → a, REM → 0. Both take 1 cycle.
- CALC→DONE when the iteration counter reaches XLEN−1.
- DONE→IDLE on out_ready with no new accept; DONE→DONE/CALC on out_ready with a simultaneous accept.
- While out_valid && !out_ready, y and illegal are held stable.
- Reset asserted mid-CALC aborts immediately: outputs return to reset values and no result is emitted.

## Timing
- Base ops: out_valid in the cycle after the accept edge (latency 1). Back-to-back throughput is 1/cycle with out_ready held high.
- M mul/div: out_valid XLEN+1 cycles after the accept edge (33 at XLEN=32). Special cases (divide by zero, overflow) have latency 1.
- Inputs are sampled only on the accept edge; a/b/sel may change freely afterwards.
- No combinational path from a/b to y.
- in_ready combinationally depends on out_ready; there is no other in→out combinational path.

## Configuration
- ALU_MULDIV_EN defined: M ops are implemented as above.
- ALU_MULDIV_EN undefined:
  - muldiv_iter is not instantiated and CALC is unreachable.
  - Any m=1 op completes with latency 1, y=0, illegal=1.
  - Base ops are unchanged.

## Structure
- Package alu_pkg holds:
  - funct3 enum for base ops (ADD…AND) and M ops (MUL…REMU)
  - FSM state typedef {IDLE, CALC, DONE}
  - parametrised helper to compute the signed-overflow and zero-divisor flags
- Sub-module muldiv_iter (XLEN parameter) contains the iterative core with start/done, opcode, operands and result. It owns the counter, shift registers and sign fix-up, and is guarded by ALU_MULDIV_EN.

## Test plan
- ADD/SUB and SLT: a=5, b=7, sel=0, ext=1 → y=0xFFFFFFFE one cycle after accept. sel=2, a=0xFFFFFFFF, b=1 → y=1; sel=3, same operands → y=0.
- SRA/SRL: a=0x80000000, b=0x24, sel=5. ext=1 → y=0xF8000000 (shift 4, upper b bits ignored); ext=0 → y=0x08000000.
- MULH: a=b=0x80000000 → y=0x40000000, out_valid exactly 33 cycles after accept, busy high for the CALC cycles. MULHSU with a=0xFFFFFFFF, b=2 → y=0xFFFFFFFF.
- Div corners: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0; DIVU x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. All four at latency 1.
- Backpressure: out_ready low for 5 cycles after a result → y, illegal and out_valid stable and in_ready=0. Raising out_ready together with a new in_valid accepts in that cycle, with the next result one cycle later.
- Reset during DIV at CALC cycle 10 → out_valid=0, y=0, busy=0 immediately; in_ready=1; no stale result after rst_n rises. With ALU_MULDIV_EN undefined, MUL → illegal=1, y=0, latency 1.
